// File: rtl/rob_pkg.sv
// Shared reorder-buffer types and sizing constants.
// DEPTH must equal 2**TAG_W so pointer arithmetic wraps for free.
package rob_pkg;
   localparam int DEPTH  = 32;
   localparam int TAG_W  = 5;
   localparam int DATA_W = 32;
   localparam int REG_W  = 5;
   localparam int CNT_W  = TAG_W + 1;

   typedef logic [TAG_W-1:0] rob_ptr_t;
   typedef logic [CNT_W-1:0] rob_cnt_t;

   typedef struct packed {
      logic              valid;
      logic              complete;
      logic [REG_W-1:0]  rd;
      logic              reg_write;
      logic              is_store;
      logic              is_branch;
      logic              pred_taken;
      logic              actual_taken;
      logic [DATA_W-1:0] data;
   } rob_entry_t;
endpackage

// File: rtl/reorder_buffer_if.sv
// Dispatch, CDB and retire bundle between the reorder buffer and its neighbours.
// master = dispatch/back-end side, slave = reorder buffer.
interface reorder_buffer_if;
   import rob_pkg::*;

   logic              Dispatch_Valid;
   logic [REG_W-1:0]  Dispatch_Rd_Reg;
   logic              Dispatch_Reg_Write;
   logic              Dispatch_Is_Store;
   logic              Dispatch_Is_Branch;
   logic              Dispatch_Pred_Taken;
   rob_ptr_t          ROB_Alloc_Tag;
   logic              ROB_Full;
   logic              ROB_Empty;

   rob_ptr_t          CDB_Tag;
   logic [DATA_W-1:0] CDB_Data;
   logic              CDB_Valid;
   logic              CDB_Branch;
   logic              CDB_Branch_Taken;

   logic              Retire_Valid;
   rob_ptr_t          Retire_Tag;
   logic [REG_W-1:0]  Retire_Rd_Reg;
   logic              Retire_Reg_Write;
   logic [DATA_W-1:0] Retire_Data;
   logic              RB_Store_Ready;
   logic              RB_Flush_Valid;

   modport master (
      output Dispatch_Valid, Dispatch_Rd_Reg, Dispatch_Reg_Write, Dispatch_Is_Store,
             Dispatch_Is_Branch, Dispatch_Pred_Taken,
             CDB_Tag, CDB_Data, CDB_Valid, CDB_Branch, CDB_Branch_Taken,
      input  ROB_Alloc_Tag, ROB_Full, ROB_Empty,
             Retire_Valid, Retire_Tag, Retire_Rd_Reg, Retire_Reg_Write, Retire_Data,
             RB_Store_Ready, RB_Flush_Valid
   );

   modport slave (
      input  Dispatch_Valid, Dispatch_Rd_Reg, Dispatch_Reg_Write, Dispatch_Is_Store,
             Dispatch_Is_Branch, Dispatch_Pred_Taken,
             CDB_Tag, CDB_Data, CDB_Valid, CDB_Branch, CDB_Branch_Taken,
      output ROB_Alloc_Tag, ROB_Full, ROB_Empty,
             Retire_Valid, Retire_Tag, Retire_Rd_Reg, Retire_Reg_Write, Retire_Data,
             RB_Store_Ready, RB_Flush_Valid
   );
endinterface

// File: rtl/rob_ptr_ctrl.sv
// Head/tail/count bookkeeping for the reorder buffer; full/empty are combinational from count.
// A flush collapses the buffer to empty just past the retiring head.
module rob_ptr_ctrl
   import rob_pkg::*;
(
   input  logic     clk,
   input  logic     rst_n,
   input  logic     alloc,
   input  logic     retire,
   input  logic     flush,
   output rob_ptr_t head,
   output rob_ptr_t tail,
   output logic     full,
   output logic     empty
);
   rob_cnt_t count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (flush) begin
         // flush always coincides with the branch retiring, so both pointers land past it
         head  <= head + 1'b1;
         tail  <= head + 1'b1;
         count <= '0;
      end else begin
         if (alloc)
            tail <= tail + 1'b1;
         if (retire)
            head <= head + 1'b1;
         if (alloc && !retire)
            count <= count + 1'b1;
         else if (retire && !alloc)
            count <= count - 1'b1;
      end
   end

   assign full  = (count == rob_cnt_t'(DEPTH));
   assign empty = (count == '0);
endmodule

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: allocates at tail, captures CDB results, retires one per cycle at head.
// Retire/flush/store-ready outputs are registered one cycle after the retire edge.
module reorder_buffer
   import rob_pkg::*;
(
   input logic             Clk,
   input logic             Rst,
   reorder_buffer_if.slave rob
);
   rob_entry_t ent [DEPTH];
   rob_entry_t head_ent;
   rob_ptr_t   head, tail;
   logic       full, empty;
   logic       retire_now, flush_now, alloc;

   logic              ret_valid, ret_reg_write, store_ready, flush_valid;
   rob_ptr_t          ret_tag;
   logic [REG_W-1:0]  ret_rd;
   logic [DATA_W-1:0] ret_data;

   rob_ptr_ctrl u_ptr (
      .clk    (Clk),
      .rst_n  (Rst),
      .alloc  (alloc),
      .retire (retire_now),
      .flush  (flush_now),
      .head   (head),
      .tail   (tail),
      .full   (full),
      .empty  (empty)
   );

   assign head_ent   = ent[head];
   assign retire_now = head_ent.valid && head_ent.complete;
   assign flush_now  = retire_now && head_ent.is_branch &&
                       (head_ent.actual_taken != head_ent.pred_taken);
   assign alloc      = rob.Dispatch_Valid && !full && !flush_now;

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         for (int i = 0; i < DEPTH; i++)
            ent[i] <= '0;
      end else if (flush_now) begin
         // wrong-path entries and any same-cycle CDB result are dropped wholesale
         for (int i = 0; i < DEPTH; i++) begin
            ent[i].valid    <= 1'b0;
            ent[i].complete <= 1'b0;
         end
      end else begin
         if (rob.CDB_Valid && ent[rob.CDB_Tag].valid) begin
            ent[rob.CDB_Tag].complete <= 1'b1;
            ent[rob.CDB_Tag].data     <= rob.CDB_Data;
            if (rob.CDB_Branch)
               ent[rob.CDB_Tag].actual_taken <= rob.CDB_Branch_Taken;
         end
         if (retire_now) begin
            ent[head].valid    <= 1'b0;
            ent[head].complete <= 1'b0;
         end
         // tail never aliases a live entry while alloc is permitted
         if (alloc)
            ent[tail] <= '{valid:        1'b1,
                           complete:     rob.Dispatch_Is_Store,
                           rd:           rob.Dispatch_Rd_Reg,
                           reg_write:    rob.Dispatch_Reg_Write,
                           is_store:     rob.Dispatch_Is_Store,
                           is_branch:    rob.Dispatch_Is_Branch,
                           pred_taken:   rob.Dispatch_Pred_Taken,
                           actual_taken: 1'b0,
                           data:         '0};
      end
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         ret_valid     <= 1'b0;
         ret_reg_write <= 1'b0;
         store_ready   <= 1'b0;
         flush_valid   <= 1'b0;
         ret_tag       <= '0;
         ret_rd        <= '0;
         ret_data      <= '0;
      end else begin
         ret_valid     <= retire_now;
         ret_reg_write <= retire_now && head_ent.reg_write && !head_ent.is_store;
         store_ready   <= retire_now && head_ent.is_store;
         flush_valid   <= flush_now;
         if (retire_now) begin
            ret_tag  <= head;
            ret_rd   <= head_ent.rd;
            ret_data <= head_ent.data;
         end
      end
   end

   assign rob.ROB_Alloc_Tag    = tail;
   assign rob.ROB_Full         = full;
   assign rob.ROB_Empty        = empty;
   assign rob.Retire_Valid     = ret_valid;
   assign rob.Retire_Tag       = ret_tag;
   assign rob.Retire_Rd_Reg    = ret_rd;
   assign rob.Retire_Reg_Write = ret_reg_write;
   assign rob.Retire_Data      = ret_data;
   assign rob.RB_Store_Ready   = store_ready;
   assign rob.RB_Flush_Valid   = flush_valid;
endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: directed scenarios with literal expectations plus random traffic
// checked every cycle against a program-order queue model.
module tb_reorder_buffer;
   logic Clk;
   logic Rst;
   int   n_chk  = 0;
   int   n_fail = 0;

   reorder_buffer_if rif ();

   reorder_buffer dut (
      .Clk (Clk),
      .Rst (Rst),
      .rob (rif.slave)
   );

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   typedef struct {
      int          tag;
      logic [4:0]  rd;
      bit          rw, st, br, pt, at, done;
      logic [31:0] data;
   } m_ent_t;

   m_ent_t      mq[$];
   int          m_next = 0;
   bit          m_rv = 0, m_sr = 0, m_fl = 0, m_rw = 0;
   int          m_tag = 0;
   logic [4:0]  m_rd = '0;
   logic [31:0] m_data = '0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Program-order model: oldest entry at the front of the queue
   always @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         mq.delete();
         m_next = 0;
         m_rv = 0; m_sr = 0; m_fl = 0; m_rw = 0;
      end else begin
         bit ret, fl, was_full;
         m_ent_t e;
         was_full = (mq.size() == 32);
         ret = (mq.size() > 0) && mq[0].done;
         fl  = ret && mq[0].br && (mq[0].at != mq[0].pt);
         m_rv = ret;
         m_fl = fl;
         m_sr = ret && mq[0].st;
         m_rw = ret && mq[0].rw && !mq[0].st;
         if (ret) begin
            m_tag  = mq[0].tag;
            m_rd   = mq[0].rd;
            m_data = mq[0].data;
         end
         if (!fl && rif.CDB_Valid)
            foreach (mq[i])
               if (mq[i].tag == int'(rif.CDB_Tag)) begin
                  mq[i].done = 1;
                  mq[i].data = rif.CDB_Data;
                  if (rif.CDB_Branch) mq[i].at = rif.CDB_Branch_Taken;
               end
         if (fl) begin
            m_next = (mq[0].tag + 1) % 32;
            mq.delete();
         end else if (ret) begin
            void'(mq.pop_front());
         end
         if (rif.Dispatch_Valid && !was_full && !fl) begin
            e.tag  = m_next;
            e.rd   = rif.Dispatch_Rd_Reg;
            e.rw   = rif.Dispatch_Reg_Write;
            e.st   = rif.Dispatch_Is_Store;
            e.br   = rif.Dispatch_Is_Branch;
            e.pt   = rif.Dispatch_Pred_Taken;
            e.at   = 0;
            e.done = rif.Dispatch_Is_Store;
            e.data = '0;
            mq.push_back(e);
            m_next = (m_next + 1) % 32;
         end
      end
   end

   always @(negedge Clk) begin
      chk("rob_full",     rif.ROB_Full,      mq.size() == 32);
      chk("rob_empty",    rif.ROB_Empty,     mq.size() == 0);
      chk("alloc_tag",    rif.ROB_Alloc_Tag, m_next);
      chk("retire_valid", rif.Retire_Valid,  m_rv);
      chk("store_ready",  rif.RB_Store_Ready, m_sr);
      chk("flush_valid",  rif.RB_Flush_Valid, m_fl);
      if (m_rv) begin
         chk("retire_tag",  rif.Retire_Tag,       m_tag);
         chk("retire_rd",   rif.Retire_Rd_Reg,    m_rd);
         chk("retire_we",   rif.Retire_Reg_Write, m_rw);
         chk("retire_data", rif.Retire_Data,      m_data);
      end
   end

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic set_disp(input bit v, input int rd, input bit rw, input bit st,
                           input bit br, input bit pt);
      rif.Dispatch_Valid      = v;
      rif.Dispatch_Rd_Reg     = 5'(rd);
      rif.Dispatch_Reg_Write  = rw;
      rif.Dispatch_Is_Store   = st;
      rif.Dispatch_Is_Branch  = br;
      rif.Dispatch_Pred_Taken = pt;
   endtask

   task automatic set_cdb(input bit v, input int tag, input logic [31:0] data,
                          input bit br, input bit tk);
      rif.CDB_Valid        = v;
      rif.CDB_Tag          = 5'(tag);
      rif.CDB_Data         = data;
      rif.CDB_Branch       = br;
      rif.CDB_Branch_Taken = tk;
   endtask

   task automatic idle();
      set_disp(0, 0, 0, 0, 0, 0);
      set_cdb(0, 0, 32'h0, 0, 0);
   endtask

   task automatic do_reset();
      Rst = 1'b0;
      idle();
      tick();
      Rst = 1'b1;
   endtask

   initial begin
      Rst = 1'b0;
      idle();
      tick();
      chk("rst_retire_valid", rif.Retire_Valid, 1'b0);
      chk("rst_store_ready",  rif.RB_Store_Ready, 1'b0);
      chk("rst_flush",        rif.RB_Flush_Valid, 1'b0);
      chk("rst_empty",        rif.ROB_Empty, 1'b1);
      chk("rst_full",         rif.ROB_Full, 1'b0);
      chk("rst_alloc_tag",    rif.ROB_Alloc_Tag, 5'd0);
      chk("rst_retire_data",  rif.Retire_Data, 32'h0);
      Rst = 1'b1;

      // Out-of-order completion, in-order retirement
      for (int i = 1; i <= 3; i++) begin
         set_disp(1, i, 1, 0, 0, 0);
         tick();
      end
      chk("s1_alloc_tag", rif.ROB_Alloc_Tag, 5'd3);
      set_disp(0, 0, 0, 0, 0, 0);
      set_cdb(1, 2, 32'hA, 0, 0); tick();
      chk("s1_no_retire", rif.Retire_Valid, 1'b0);
      set_cdb(1, 0, 32'hB, 0, 0); tick();
      set_cdb(1, 1, 32'hC, 0, 0); tick();
      chk("s1_r0_tag",  rif.Retire_Tag, 5'd0);
      chk("s1_r0_rd",   rif.Retire_Rd_Reg, 5'd1);
      chk("s1_r0_data", rif.Retire_Data, 32'hB);
      set_cdb(0, 0, 32'h0, 0, 0); tick();
      chk("s1_r1_tag",  rif.Retire_Tag, 5'd1);
      chk("s1_r1_data", rif.Retire_Data, 32'hC);
      tick();
      chk("s1_r2_rd",   rif.Retire_Rd_Reg, 5'd3);
      chk("s1_r2_data", rif.Retire_Data, 32'hA);
      tick();
      chk("s1_idle_valid", rif.Retire_Valid, 1'b0);

      // Fill to full, reject an extra dispatch, free one slot
      do_reset();
      for (int i = 0; i < 32; i++) begin
         set_disp(1, i, 1, 0, 0, 0);
         tick();
      end
      chk("s2_full", rif.ROB_Full, 1'b1);
      chk("s2_alloc_wrap", rif.ROB_Alloc_Tag, 5'd0);
      tick();
      chk("s2_full_hold", rif.ROB_Full, 1'b1);
      chk("s2_alloc_hold", rif.ROB_Alloc_Tag, 5'd0);
      set_disp(0, 0, 0, 0, 0, 0);
      set_cdb(1, 0, 32'h55, 0, 0); tick();
      set_cdb(0, 0, 32'h0, 0, 0); tick();
      chk("s2_retire_tag", rif.Retire_Tag, 5'd0);
      chk("s2_retire_data", rif.Retire_Data, 32'h55);
      chk("s2_full_drop", rif.ROB_Full, 1'b0);
      chk("s2_next_tag", rif.ROB_Alloc_Tag, 5'd0);
      set_disp(1, 9, 1, 0, 0, 0);
      set_cdb(1, 1, 32'h66, 0, 0); tick();
      chk("s2_refull", rif.ROB_Full, 1'b1);
      set_disp(0, 0, 0, 0, 0, 0);
      set_cdb(1, 2, 32'h77, 0, 0); tick();
      chk("s5_retire1_tag", rif.Retire_Tag, 5'd1);
      chk("s5_count31", rif.ROB_Full, 1'b0);
      // dispatch and retire on the same edge at count 31
      set_disp(1, 10, 1, 0, 0, 0);
      set_cdb(0, 0, 32'h0, 0, 0); tick();
      chk("s5_still_not_full", rif.ROB_Full, 1'b0);
      chk("s5_alloc_tag", rif.ROB_Alloc_Tag, 5'd2);
      chk("s5_retire2_data", rif.Retire_Data, 32'h77);

      // Store retires two edges after dispatch
      do_reset();
      set_disp(1, 4, 1, 1, 0, 0); tick();
      chk("s3_not_yet", rif.Retire_Valid, 1'b0);
      set_disp(0, 0, 0, 0, 0, 0); tick();
      chk("s3_valid", rif.Retire_Valid, 1'b1);
      chk("s3_store_ready", rif.RB_Store_Ready, 1'b1);
      chk("s3_reg_write", rif.Retire_Reg_Write, 1'b0);
      tick();
      chk("s3_store_ready_drop", rif.RB_Store_Ready, 1'b0);

      // Mispredicted branch at tag 5 flushes younger tags 6..9
      do_reset();
      for (int i = 0; i < 5; i++) begin
         set_disp(1, i, 0, 1, 0, 0);
         tick();
      end
      set_disp(1, 0, 0, 0, 1, 0); tick();
      for (int i = 6; i <= 9; i++) begin
         set_disp(1, i, 1, 0, 0, 0);
         tick();
      end
      set_disp(0, 0, 0, 0, 0, 0);
      repeat (3) tick();
      set_cdb(1, 5, 32'h99, 1, 1); tick();
      set_cdb(0, 0, 32'h0, 0, 0); tick();
      chk("s4_flush", rif.RB_Flush_Valid, 1'b1);
      chk("s4_retire_tag", rif.Retire_Tag, 5'd5);
      chk("s4_empty", rif.ROB_Empty, 1'b1);
      chk("s4_alloc_tag", rif.ROB_Alloc_Tag, 5'd6);
      tick();
      chk("s4_flush_drop", rif.RB_Flush_Valid, 1'b0);
      set_cdb(1, 7, 32'h1234, 0, 0); tick();
      set_cdb(0, 0, 32'h0, 0, 0); tick();
      chk("s4_stale_cdb", rif.Retire_Valid, 1'b0);
      chk("s4_still_empty", rif.ROB_Empty, 1'b1);

      // Random traffic: a dispatch-heavy phase, then a balanced one
      for (int ph = 0; ph < 2; ph++) begin
         for (int n = 0; n < 1500; n++) begin
            bit st;
            st = ($urandom_range(0, 4) == 0);
            set_disp(($urandom_range(0, 9) < (ph == 0 ? 9 : 5)), $urandom_range(0, 31),
                     $urandom_range(0, 1), st, !st && ($urandom_range(0, 3) == 0),
                     $urandom_range(0, 1));
            set_cdb(($urandom_range(0, 9) < (ph == 0 ? 3 : 6)), $urandom_range(0, 31),
                    $urandom, $urandom_range(0, 1), $urandom_range(0, 1));
            if (mq.size() > 0 && $urandom_range(0, 2) == 0)
               rif.CDB_Tag = 5'(mq[0].tag);
            tick();
         end
      end

      // Asynchronous reset mid-stream with live entries
      do_reset();
      for (int i = 0; i < 11; i++) begin
         set_disp(1, i, 1, 0, 0, 0);
         tick();
      end
      set_disp(0, 0, 0, 0, 0, 0);
      set_cdb(1, 0, 32'hBEEF, 0, 0); tick();
      set_cdb(0, 0, 32'h0, 0, 0); tick();
      chk("s6_pre_valid", rif.Retire_Valid, 1'b1);
      #3 Rst = 1'b0;
      #1;
      chk("s6_valid_clr", rif.Retire_Valid, 1'b0);
      chk("s6_empty", rif.ROB_Empty, 1'b1);
      chk("s6_alloc_tag", rif.ROB_Alloc_Tag, 5'd0);
      chk("s6_data_clr", rif.Retire_Data, 32'h0);
      tick();
      Rst = 1'b1;
      tick();
      chk("s6_post_empty", rif.ROB_Empty, 1'b1);
      chk("s6_post_alloc", rif.ROB_Alloc_Tag, 5'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
